sample_frame_buffer: RTL and testbench
======================================

SAMPLE_FRAME_BUFFER -- requirements
Module: sample_frame_buffer

Interface
REQ-001 SHALL have parameter N, default 16: sample word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: words per frame; power of two, 4 to 64.
REQ-003 SHALL have port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port i_valid, input, 1: i_word carries a sample this cycle.
REQ-006 SHALL have port i_word, input, N: sample data.
REQ-007 SHALL have port o_ready, output, 1: buffer accepts a sample this cycle.
REQ-008 SHALL have port o_words, output, N*DEPTH: completed frame; word k at bits [k*N +: N].
REQ-009 SHALL have port o_frame_valid, output, 1: o_words holds an unconsumed frame.
REQ-010 SHALL have port i_frame_ack, input, 1: consumer releases the current frame.
REQ-011 SHALL have port o_fill, output, log2(DEPTH)+1: words written into the fill bank.
REQ-012 SHALL have port o_frame_cnt, output, 8: count of frames published, wrapping.

Function
REQ-013 SHALL hold two banks of DEPTH x N registers, one fill bank and one read bank; o_words SHALL be driven from the read bank registers only.
REQ-014 A sample SHALL be accepted on a rising edge with i_valid=1 and o_ready=1, written to the fill bank at index wr_ptr, and wr_ptr/o_fill SHALL increment by 1.
REQ-015 i_valid while o_ready=0 SHALL be ignored, with no state change.
REQ-016 On acceptance with wr_ptr=DEPTH-1 and a free read side (o_frame_valid=0, or i_frame_ack=1 in the same cycle), banks SHALL swap at that edge; next cycle: o_frame_valid=1, o_frame_cnt+1, wr_ptr=0, o_fill=0, o_ready=1.
REQ-017 On acceptance with wr_ptr=DEPTH-1 and a held read side (o_frame_valid=1, i_frame_ack=0), the write FSM SHALL move FILL->WAIT; next cycle o_ready=0 and o_fill=DEPTH.
REQ-018 In WAIT, i_frame_ack=1 SHALL swap banks at that edge; next cycle: state FILL, o_ready=1, o_frame_valid stays 1, o_frame_cnt+1, o_fill=0.
REQ-019 i_frame_ack=1 with o_frame_valid=1 and no swap at that edge SHALL clear o_frame_valid next cycle.
REQ-020 i_frame_ack=1 with o_frame_valid=0 SHALL be ignored.
REQ-021 o_words SHALL be stable whenever o_frame_valid=1 and no swap occurs; the bank being filled SHALL never be visible on o_words.
REQ-022 Sustained input, one sample per cycle, SHALL never stall provided i_frame_ack arrives within DEPTH cycles of o_frame_valid rising.
REQ-023 All outputs SHALL be registered; sample-to-frame latency SHALL be 1 cycle after the last word's edge.

Reset
REQ-024 With i_rst=1 at an edge: both banks SHALL be cleared to 0, wr_ptr=0, state FILL; next cycle: o_words=0, o_frame_valid=0, o_fill=0, o_frame_cnt=0, o_ready=1.
REQ-025 i_valid and i_frame_ack SHALL be ignored in any cycle where i_rst=1.
REQ-026 Reset mid-frame or in WAIT SHALL discard the partial and pending frames, with no frame published.

Configuration
REQ-027 With macro SAMPLE_FRAME_BUFFER_BITREV_EN defined, sample number j of a frame SHALL be stored at the bit-reversed index of j over log2(DEPTH) bits, giving FFT input order.
REQ-028 Without SAMPLE_FRAME_BUFFER_BITREV_EN, sample j SHALL be stored at index j (natural order).

Verification
REQ-029 Reset, then 16 samples 0x0001..0x0010 on consecutive cycles, ack low -> o_frame_valid=1 one cycle after the 16th; natural build word k=k+1; BITREV build word 1=0x0009, word 8=0x0002; o_frame_cnt=1.
REQ-030 Two frames back-to-back, ack low -> o_ready=0 after 32nd accept, o_fill=16, o_words still frame 1; ack pulse -> o_words frame 2, o_ready=1, o_frame_cnt=2.
REQ-031 Ack asserted on same edge as 16th sample of frame 2 -> swap without stall, o_frame_valid stays 1, o_words=frame 2.
REQ-032 Ack with o_frame_valid=0; i_valid while o_ready=0 -> no change to o_fill, o_words, o_frame_cnt.
REQ-033 i_rst after 7 samples of a frame -> all outputs at reset values; 16 new samples publish only the new data, o_frame_cnt=1.
REQ-034 Publish 256 frames with immediate ack -> o_frame_cnt wraps to 0x00.

Source files
------------

// File: rtl/sample_frame_buffer_if.sv
// Sample/frame handshake bundle for sample_frame_buffer.
// master: sample producer and frame consumer; slave: the buffer itself.
interface sample_frame_buffer_if #(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned FW = $clog2(DEPTH) + 1;

  logic                 i_valid;
  logic [N-1:0]         i_word;
  logic                 o_ready;
  logic [N*DEPTH-1:0]   o_words;
  logic                 o_frame_valid;
  logic                 i_frame_ack;
  logic [FW-1:0]        o_fill;
  logic [7:0]           o_frame_cnt;

  modport master (
    output i_valid, i_word, i_frame_ack,
    input  o_ready, o_words, o_frame_valid, o_fill, o_frame_cnt
  );

  modport slave (
    input  i_valid, i_word, i_frame_ack,
    output o_ready, o_words, o_frame_valid, o_fill, o_frame_cnt
  );
endinterface

// File: rtl/sample_frame_buffer.sv
// Double-banked sample-to-frame buffer: samples fill one bank while the
// consumer reads a published frame from the other.
// Optional macro SAMPLE_FRAME_BUFFER_BITREV_EN stores samples in
// bit-reversed (FFT input) order; default is natural order.
module sample_frame_buffer #(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  sample_frame_buffer_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam int unsigned WW = N * DEPTH;
  localparam logic [FW-1:0] LAST_IDX = FW'(DEPTH - 1);
  localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

  typedef enum logic {ST_FILL, ST_WAIT} state_t;

  state_t          state_q;
  logic [FW-1:0]   fill_q;
  logic [WW-1:0]   fill_bank;
  logic [WW-1:0]   read_bank;
  logic            frame_valid_q;
  logic            ready_q;
  logic [7:0]      frame_cnt_q;

  logic            accept_c;
  logic            last_c;
  logic            read_free_c;
  logic            swap_c;
  logic [AW-1:0]   wr_idx_c;
  logic [WW-1:0]   fill_merged_c;

`ifdef SAMPLE_FRAME_BUFFER_BITREV_EN
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(AW); i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  // Sample j lands at the bit-reversed slot of j.
  assign wr_idx_c = bitrev(fill_q[AW-1:0]);
`else
  // Sample j lands at slot j.
  assign wr_idx_c = fill_q[AW-1:0];
`endif

  // Acceptance, swap decision and the fill bank including this cycle's word.
  always_comb begin
    accept_c      = bus.i_valid && ready_q;
    last_c        = accept_c && (fill_q == LAST_IDX);
    read_free_c   = !frame_valid_q || bus.i_frame_ack;
    swap_c        = (last_c && read_free_c) ||
                    ((state_q == ST_WAIT) && bus.i_frame_ack);
    fill_merged_c = fill_bank;
    if (accept_c) fill_merged_c[32'(wr_idx_c)*N +: N] = bus.i_word;
  end

  // Write FSM, bank storage, publish/release bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_FILL;
      fill_q        <= '0;
      fill_bank     <= '0;
      read_bank     <= '0;
      frame_valid_q <= 1'b0;
      ready_q       <= 1'b1;
      frame_cnt_q   <= 8'd0;
    end else begin
      fill_bank <= fill_merged_c;

      if (swap_c) begin
        read_bank     <= fill_merged_c;
        frame_valid_q <= 1'b1;
        frame_cnt_q   <= frame_cnt_q + 8'd1;
      end else if (bus.i_frame_ack && frame_valid_q) begin
        frame_valid_q <= 1'b0;
      end

      case (state_q)
        ST_FILL: begin
          if (accept_c) begin
            if (fill_q == LAST_IDX) begin
              if (read_free_c) begin
                fill_q <= '0;
              end else begin
                state_q <= ST_WAIT;
                ready_q <= 1'b0;
                fill_q  <= FULL_CNT;
              end
            end else begin
              fill_q <= fill_q + FW'(1);
            end
          end
        end
        ST_WAIT: begin
          if (bus.i_frame_ack) begin
            state_q <= ST_FILL;
            ready_q <= 1'b1;
            fill_q  <= '0;
          end
        end
        default: begin
          state_q <= ST_FILL;
          ready_q <= 1'b1;
          fill_q  <= '0;
        end
      endcase
    end
  end

  // Outputs come straight from registers; only the read bank is visible.
  assign bus.o_ready       = ready_q;
  assign bus.o_words       = read_bank;
  assign bus.o_frame_valid = frame_valid_q;
  assign bus.o_fill        = fill_q;
  assign bus.o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Scoreboard bench for sample_frame_buffer (N=16, DEPTH=16).
module tb_sample_frame_buffer;
  localparam int unsigned N     = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WW    = N * DEPTH;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  sample_frame_buffer_if #(.N(N), .DEPTH(DEPTH)) bus ();
  sample_frame_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] mdl_bank;
  int            mdl_j;

  function automatic int pos(input int j);
`ifdef SAMPLE_FRAME_BUFFER_BITREV_EN
    return ((j & 1) << 3) | ((j & 2) << 1) | ((j & 4) >> 1) | ((j & 8) >> 3);
`else
    return j;
`endif
  endfunction

  function automatic logic [WW-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Drive one sample; the model records it only if the buffer is ready.
  task automatic send(input logic [N-1:0] w, input logic ack);
    bus.i_valid     = 1'b1;
    bus.i_word      = w;
    bus.i_frame_ack = ack;
    if (bus.o_ready === 1'b1) begin
      mdl_bank[pos(mdl_j)*N +: N] = w;
      mdl_j++;
      if (mdl_j == int'(DEPTH)) begin
        exp_q.push_back(mdl_bank);
        mdl_j = 0;
      end
    end
    tick();
    bus.i_valid     = 1'b0;
    bus.i_frame_ack = 1'b0;
  endtask

  // Reset with valid/ack held high, which must be ignored.
  task automatic do_reset();
    i_rst           = 1'b1;
    bus.i_valid     = 1'b1;
    bus.i_word      = 16'hdead;
    bus.i_frame_ack = 1'b1;
    tick();
    i_rst           = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_frame_ack = 1'b0;
    mdl_j    = 0;
    mdl_bank = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.o_words !== '0) begin errors++; $display("FAIL reset_words got=%h exp=0", bus.o_words); end
    checks++; if (bus.o_frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", bus.o_frame_valid); end
    checks++; if (bus.o_fill !== 5'd0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", bus.o_fill); end
    checks++; if (bus.o_frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.o_frame_cnt); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
  endtask

  task automatic test_single_frame();
    logic [WW-1:0] w;
    logic [N-1:0]  e1, e8;
    do_reset();
    for (int k = 1; k <= 15; k++) send(16'(k), 1'b0);
    checks++; if (bus.o_fill !== 5'd15) begin errors++; $display("FAIL single_fill15 got=%0d exp=15", bus.o_fill); end
    checks++; if (bus.o_frame_valid !== 1'b0) begin errors++; $display("FAIL single_fv_early got=%b exp=0", bus.o_frame_valid); end
    send(16'd16, 1'b0);
    checks++; if (bus.o_frame_valid !== 1'b1) begin errors++; $display("FAIL single_fv got=%b exp=1", bus.o_frame_valid); end
    checks++; if (bus.o_frame_cnt !== 8'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", bus.o_frame_cnt); end
    checks++; if (bus.o_fill !== 5'd0) begin errors++; $display("FAIL single_fill got=%0d exp=0", bus.o_fill); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", bus.o_ready); end
    w = pop_exp();
    checks++; if (bus.o_words !== w) begin errors++; $display("FAIL single_words got=%h exp=%h", bus.o_words, w); end
`ifdef SAMPLE_FRAME_BUFFER_BITREV_EN
    e1 = 16'h0009; e8 = 16'h0002;
`else
    e1 = 16'h0002; e8 = 16'h0009;
`endif
    w = bus.o_words;
    checks++; if (w[1*N +: N] !== e1) begin errors++; $display("FAIL single_word1 got=%h exp=%h", w[1*N +: N], e1); end
    checks++; if (w[8*N +: N] !== e8) begin errors++; $display("FAIL single_word8 got=%h exp=%h", w[8*N +: N], e8); end
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] f1, f2;
    do_reset();
    for (int k = 0; k < 16; k++) send(16'(16'h0101 + k), 1'b0);
    f1 = pop_exp();
    checks++; if (bus.o_words !== f1) begin errors++; $display("FAIL b2b_f1 got=%h exp=%h", bus.o_words, f1); end
    for (int k = 16; k < 32; k++) send(16'(16'h0101 + k), 1'b0);
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready got=%b exp=0", bus.o_ready); end
    checks++; if (bus.o_fill !== 5'd16) begin errors++; $display("FAIL b2b_stall_fill got=%0d exp=16", bus.o_fill); end
    checks++; if (bus.o_words !== f1) begin errors++; $display("FAIL b2b_hold got=%h exp=%h", bus.o_words, f1); end
    // valid while stalled must change nothing
    bus.i_valid = 1'b1; bus.i_word = 16'hffff;
    tick(); tick();
    bus.i_valid = 1'b0;
    checks++; if (bus.o_fill !== 5'd16) begin errors++; $display("FAIL ign_fill got=%0d exp=16", bus.o_fill); end
    checks++; if (bus.o_words !== f1) begin errors++; $display("FAIL ign_words got=%h exp=%h", bus.o_words, f1); end
    checks++; if (bus.o_frame_cnt !== 8'd1) begin errors++; $display("FAIL ign_cnt got=%0d exp=1", bus.o_frame_cnt); end
    bus.i_frame_ack = 1'b1;
    tick();
    bus.i_frame_ack = 1'b0;
    f2 = pop_exp();
    checks++; if (bus.o_words !== f2) begin errors++; $display("FAIL b2b_f2 got=%h exp=%h", bus.o_words, f2); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", bus.o_ready); end
    checks++; if (bus.o_frame_cnt !== 8'd2) begin errors++; $display("FAIL b2b_cnt got=%0d exp=2", bus.o_frame_cnt); end
    checks++; if (bus.o_frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_fv got=%b exp=1", bus.o_frame_valid); end
    checks++; if (bus.o_fill !== 5'd0) begin errors++; $display("FAIL b2b_fill got=%0d exp=0", bus.o_fill); end
  endtask

  task automatic test_ack_same_edge();
    logic [WW-1:0] fa, fb;
    do_reset();
    for (int k = 0; k < 16; k++) send(16'(16'h0a00 + k), 1'b0);
    fa = pop_exp();
    checks++; if (bus.o_words !== fa) begin errors++; $display("FAIL same_fa got=%h exp=%h", bus.o_words, fa); end
    for (int k = 0; k < 15; k++) send(16'(16'h0b00 + k), 1'b0);
    send(16'h0b0f, 1'b1);
    fb = pop_exp();
    checks++; if (bus.o_words !== fb) begin errors++; $display("FAIL same_fb got=%h exp=%h", bus.o_words, fb); end
    checks++; if (bus.o_frame_valid !== 1'b1) begin errors++; $display("FAIL same_fv got=%b exp=1", bus.o_frame_valid); end
    checks++; if (bus.o_frame_cnt !== 8'd2) begin errors++; $display("FAIL same_cnt got=%0d exp=2", bus.o_frame_cnt); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL same_ready got=%b exp=1", bus.o_ready); end
  endtask

  task automatic test_ack_release();
    logic [WW-1:0] held;
    for (int k = 0; k < 3; k++) send(16'(16'h0c00 + k), 1'b0);
    held = bus.o_words;
    bus.i_frame_ack = 1'b1;
    tick();
    checks++; if (bus.o_frame_valid !== 1'b0) begin errors++; $display("FAIL rel_fv got=%b exp=0", bus.o_frame_valid); end
    tick();
    bus.i_frame_ack = 1'b0;
    checks++; if (bus.o_fill !== 5'd3) begin errors++; $display("FAIL rel_fill got=%0d exp=3", bus.o_fill); end
    checks++; if (bus.o_words !== held) begin errors++; $display("FAIL rel_words got=%h exp=%h", bus.o_words, held); end
    checks++; if (bus.o_frame_cnt !== 8'd2) begin errors++; $display("FAIL rel_cnt got=%0d exp=2", bus.o_frame_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [WW-1:0] w;
    do_reset();
    for (int k = 0; k < 7; k++) send(16'(16'haa00 + k), 1'b0);
    do_reset();
    checks++; if (bus.o_fill !== 5'd0) begin errors++; $display("FAIL mid_fill got=%0d exp=0", bus.o_fill); end
    checks++; if (bus.o_frame_valid !== 1'b0) begin errors++; $display("FAIL mid_fv got=%b exp=0", bus.o_frame_valid); end
    checks++; if (bus.o_words !== '0) begin errors++; $display("FAIL mid_words got=%h exp=0", bus.o_words); end
    checks++; if (bus.o_frame_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt0 got=%0d exp=0", bus.o_frame_cnt); end
    for (int k = 0; k < 16; k++) send(16'(16'h5500 + k), 1'b0);
    w = pop_exp();
    checks++; if (bus.o_words !== w) begin errors++; $display("FAIL mid_words_new got=%h exp=%h", bus.o_words, w); end
    checks++; if (bus.o_frame_cnt !== 8'd1) begin errors++; $display("FAIL mid_cnt got=%0d exp=1", bus.o_frame_cnt); end
  endtask

  task automatic test_wrap();
    logic [WW-1:0] w;
    int stalls;
    do_reset();
    stalls = 0;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 16; k++) begin
        if (bus.o_ready !== 1'b1) stalls++;
        send(16'($urandom()), 1'b1);
      end
      w = pop_exp();
      checks++; if (bus.o_words !== w) begin errors++; $display("FAIL wrap_words f=%0d got=%h exp=%h", f, bus.o_words, w); end
      if (f == 254) begin
        checks++; if (bus.o_frame_cnt !== 8'd255) begin errors++; $display("FAIL wrap_cnt255 got=%0d exp=255", bus.o_frame_cnt); end
      end
    end
    checks++; if (bus.o_frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt got=%0d exp=0", bus.o_frame_cnt); end
    checks++; if (stalls !== 0) begin errors++; $display("FAIL wrap_stalls got=%0d exp=0", stalls); end
    checks++; if (bus.o_frame_valid !== 1'b1) begin errors++; $display("FAIL wrap_fv got=%b exp=1", bus.o_frame_valid); end
  endtask

  initial begin
    i_rst           = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_word      = '0;
    bus.i_frame_ack = 1'b0;
    mdl_j           = 0;
    mdl_bank        = '0;
    tick();
    tick();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ack_same_edge();
    test_ack_release();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
